// File: rtl/mtm_alu_deser_param_if.sv
// Bus between the ALU command deserializer and its user: the serial
// input line plus the one-entry valid/ready result register.
interface mtm_alu_deser_param_if #(
    parameter int DATA_W = 32
);
    logic              sin;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic [7:0]        ctl_out;
    logic              out_valid;
    logic              out_ready;
    logic              ovf;

    // Driver of the serial line and consumer of the results
    modport master (
        output sin, out_ready,
        input  A, B, ctl_out, out_valid, ovf
    );

    // The deserializer itself
    modport slave (
        input  sin, out_ready,
        output A, B, ctl_out, out_valid, ovf
    );
endinterface

// File: rtl/mtm_alu_deser_param.sv
// Serial ALU command deserializer, operand width DATA_W.
// Receives 2*BYTES data frames (A then B, MSB byte first) and one CTL
// frame, checks framing, frame types and CRC-4, and hands the result to a
// one-entry valid/ready output register. Errors produce code C9 (framing)
// or A5 (CRC) with A/B left unchanged.
// Optional: define FRAME_TIMEOUT_EN to abort a partial packet after
// TIMEOUT_CYC idle cycles between frames.
module mtm_alu_deser_param #(
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    mtm_alu_deser_param_if.slave bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int FCW   = $clog2(2 * BYTES + 1);
    localparam logic [FCW-1:0] LAST_FRM = FCW'(2 * BYTES);

    // Reject parameter sets the frame format cannot represent
    if (DATA_W % 8 != 0 || DATA_W < 8 || DATA_W > 64 || TIMEOUT_CYC < 1) begin : g_param_chk
        $error("mtm_alu_deser_param: DATA_W must be 8..64 in steps of 8, TIMEOUT_CYC >= 1");
    end

    typedef enum logic [1:0] {IDLE, RX, RESYNC} state_t;

    state_t            state;
    logic [3:0]        bit_cnt;
    logic [FCW-1:0]    frame_cnt;
    logic [7:0]        pay;
    logic              type_err;
    logic [DATA_W-1:0] a_sh;
    logic [DATA_W-1:0] b_sh;

    logic              res_fire;
    logic              res_ok;
    logic [7:0]        res_ctl;

    // CRC-4, x^4+x+1, init 0, MSB first
    function automatic logic [3:0] crc4(input logic [2*DATA_W+3:0] msg);
        logic [3:0] c;
        logic       fb;
        c = 4'h0;
        for (int i = 2*DATA_W+3; i >= 0; i--) begin
            fb = c[3] ^ msg[i];
            c  = {c[2:0], 1'b0} ^ (fb ? 4'h3 : 4'h0);
        end
        return c;
    endfunction

`ifdef FRAME_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_CYC + 1);
    logic [TOW-1:0] to_cnt;
    logic           to_abort;
    assign to_abort = (state == IDLE) && bus.sin && (frame_cnt != '0) &&
                      (to_cnt == TOW'(TIMEOUT_CYC - 1));
`endif

    // Result event: a type error is flagged at the type bit but reported at
    // the stop bit, so the rest of the frame is not mistaken for new frames.
    always_comb begin
        res_fire = 1'b0;
        res_ok   = 1'b0;
        res_ctl  = 8'hC9;
        if (state == RX && bit_cnt == 4'd10) begin
            if (!bus.sin || type_err) begin
                res_fire = 1'b1;
            end else if (frame_cnt == LAST_FRM) begin
                res_fire = 1'b1;
                if (crc4({a_sh, b_sh, 1'b1, pay[6:4]}) == pay[3:0]) begin
                    res_ok  = 1'b1;
                    res_ctl = pay;
                end else begin
                    res_ctl = 8'hA5;
                end
            end
        end
`ifdef FRAME_TIMEOUT_EN
        if (to_abort) res_fire = 1'b1;
`endif
    end

    // Receive FSM: frame hunting, bit/frame counting, operand assembly
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            bit_cnt   <= 4'd0;
            frame_cnt <= '0;
            pay       <= 8'h00;
            type_err  <= 1'b0;
            a_sh      <= '1;
            b_sh      <= '1;
`ifdef FRAME_TIMEOUT_EN
            to_cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!bus.sin) begin
                        state   <= RX;
                        bit_cnt <= 4'd1;
`ifdef FRAME_TIMEOUT_EN
                        to_cnt  <= '0;
`endif
                    end
`ifdef FRAME_TIMEOUT_EN
                    else if (frame_cnt == '0) begin
                        to_cnt <= '0;
                    end else if (to_abort) begin
                        state     <= RESYNC;
                        frame_cnt <= '0;
                        to_cnt    <= '0;
                    end else begin
                        to_cnt <= to_cnt + TOW'(1);
                    end
`endif
                end
                RX: begin
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd1)
                        type_err <= (bus.sin != (frame_cnt == LAST_FRM));
                    if (bit_cnt >= 4'd2 && bit_cnt <= 4'd9)
                        pay <= {pay[6:0], bus.sin};
                    if (bit_cnt == 4'd10) begin
                        if (!bus.sin || type_err) begin
                            state     <= RESYNC;
                            frame_cnt <= '0;
                        end else if (frame_cnt == LAST_FRM) begin
                            state     <= res_ok ? IDLE : RESYNC;
                            frame_cnt <= '0;
                        end else begin
                            state     <= IDLE;
                            frame_cnt <= frame_cnt + FCW'(1);
                            if (frame_cnt < FCW'(BYTES))
                                a_sh <= (a_sh << 8) | DATA_W'(pay);
                            else
                                b_sh <= (b_sh << 8) | DATA_W'(pay);
                        end
                    end
                end
                RESYNC: begin
                    if (bus.sin) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // One-entry output register; a result arriving while it is full and not
    // being popped is dropped and latched into the sticky ovf flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.A         <= '1;
            bus.B         <= '1;
            bus.ctl_out   <= 8'hFF;
            bus.out_valid <= 1'b0;
            bus.ovf       <= 1'b0;
        end else if (res_fire && (!bus.out_valid || bus.out_ready)) begin
            bus.out_valid <= 1'b1;
            bus.ctl_out   <= res_ctl;
            if (res_ok) begin
                bus.A <= a_sh;
                bus.B <= b_sh;
            end
        end else begin
            if (res_fire)      bus.ovf       <= 1'b1;
            if (bus.out_ready) bus.out_valid <= 1'b0;
        end
    end
endmodule
